// File: rtl/mem_access_stage_pkg.sv
// Shared types and helpers for the MEM stage: access sizes, FSM states,
// captured control bundle, byte-lane enables and load extension.
package mem_access_stage_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [1:0] size;
    logic       ld_unsigned;
    logic [1:0] wb_ctl;
  } ctl_t;

  // Size 3 behaves as a word everywhere.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 4'b0001 << off;
      SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data onto every lane it may target.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: return {4{wdata[7:0]}};
      SIZE_HALF: return {2{wdata[15:0]}};
      default:   return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] off,
                                              input logic uns, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SIZE_HALF: return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default:   return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_dmem_array.sv
// Data memory: DEPTH x 32 words, synchronous byte-enabled write,
// combinational read so the stage can register the extended result directly.
module dmem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata_c
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata_c = mem[idx];

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage with MEM/WB register: branch resolve, sub-word loads/stores
// on an internal RAM with configurable access latency and upstream stall.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MEM_LAT = 0,
  parameter int unsigned DEST_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              branch,
  input  logic              zero,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  input  logic [1:0]        wb_ctl,
  input  logic [DEST_W-1:0] dest,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              pc_src,
  output logic              out_valid,
  output logic              reg_write,
  output logic              mem_reg,
  output logic [DEST_W-1:0] dest_out,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] addr_out,
  output logic              misalign
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              accept, commit, is_mem_in;
  ctl_t              ctl_in, ctl_q, ctl;
  logic [DEST_W-1:0] dest_q, op_dest;
  logic [ADDR_W-1:0] addr_q, op_addr;
  logic [31:0]       wdata_q, op_wdata;
  logic              op_mis, is_load;
  logic [3:0]        we;
  logic [31:0]       ram_rdata, ld_data;

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid & in_ready & ~flush;
  assign pc_src    = in_valid & in_ready & branch & zero;
  assign is_mem_in = mem_read | mem_write;
  assign ctl_in    = ctl_t'{mem_read, mem_write, size, ld_unsigned, wb_ctl};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state; commit marks the edge that performs the access and loads MEM/WB.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mem_in && (MEM_LAT != 0)) begin
            state_nx = BUSY;
            cnt_nx   = CNT_W'(MEM_LAT);
          end else begin
            commit = 1'b1;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_nx = IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_nx = IDLE;
          commit   = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_q   <= '0;
      dest_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      ctl_q   <= ctl_in;
      dest_q  <= dest;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // In IDLE the op is taken straight from the inputs so single-cycle ops need no capture.
  always_comb begin
    ctl      = ctl_in;
    op_dest  = dest;
    op_addr  = addr;
    op_wdata = wdata;
    if (state == BUSY) begin
      ctl      = ctl_q;
      op_dest  = dest_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
    end
  end

  assign op_mis  = (ctl.mem_read | ctl.mem_write) & misaligned(ctl.size, op_addr[1:0]);
  assign is_load = ctl.mem_read & ~ctl.mem_write & ~op_mis;
  assign we      = (commit & rst & ctl.mem_write & ~op_mis) ? byte_en(ctl.size, op_addr[1:0]) : 4'b0000;
  assign ld_data = load_extend(ctl.size, op_addr[1:0], ctl.ld_unsigned, ram_rdata);

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_dmem (
    .clk     (clk),
    .we      (we),
    .idx     (op_addr[2 +: IDX_W]),
    .wdata   (store_lanes(ctl.size, op_wdata)),
    .rdata_c (ram_rdata)
  );

  // MEM/WB register; flush and bubbles leave out_valid/reg_write/misalign low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      reg_write <= 1'b0;
      misalign  <= 1'b0;
      mem_reg   <= 1'b0;
      dest_out  <= '0;
      rdata     <= '0;
      addr_out  <= '0;
    end else begin
      out_valid <= commit;
      reg_write <= commit & ctl.wb_ctl[1] & ~op_mis;
      misalign  <= commit & op_mis;
      if (commit) begin
        mem_reg  <= ctl.wb_ctl[0];
        dest_out <= op_dest;
        rdata    <= is_load ? ld_data : 32'h0;
        addr_out <= op_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: one instance with MEM_LAT=0 and one with MEM_LAT=3,
// checked every cycle against a byte-level memory model plus literal expectations.
module tb_mem_access_stage;

  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_nxt = 1'b0;
  logic sel = 1'b0;
  logic iv = 1'b0, br = 1'b0, zr = 1'b0, fl = 1'b0, mr = 1'b0, mw = 1'b0, lu = 1'b0;
  logic [1:0]  sz = 2'd0, wb = 2'd0;
  logic [4:0]  ds = 5'd0;
  logic [31:0] ad = 32'd0, wd = 32'd0;

  logic [1:0]  iv_d, fl_d, rdy, pcs, ov, rwr, mrg, mal;
  logic [4:0]  dso [2];
  logic [31:0] rd  [2];
  logic [31:0] ao  [2];

  assign iv_d = {iv & sel, iv & ~sel};
  assign fl_d = {fl & sel, fl & ~sel};

  mem_access_stage #(.DEPTH(1024), .ADDR_W(32), .MEM_LAT(0), .DEST_W(5)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv_d[0]), .in_ready(rdy[0]), .flush(fl_d[0]),
    .branch(br), .zero(zr), .mem_read(mr), .mem_write(mw), .size(sz), .ld_unsigned(lu),
    .wb_ctl(wb), .dest(ds), .addr(ad), .wdata(wd), .pc_src(pcs[0]), .out_valid(ov[0]),
    .reg_write(rwr[0]), .mem_reg(mrg[0]), .dest_out(dso[0]), .rdata(rd[0]),
    .addr_out(ao[0]), .misalign(mal[0]));

  mem_access_stage #(.DEPTH(1024), .ADDR_W(32), .MEM_LAT(LAT1), .DEST_W(5)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv_d[1]), .in_ready(rdy[1]), .flush(fl_d[1]),
    .branch(br), .zero(zr), .mem_read(mr), .mem_write(mw), .size(sz), .ld_unsigned(lu),
    .wb_ctl(wb), .dest(ds), .addr(ad), .wdata(wd), .pc_src(pcs[1]), .out_valid(ov[1]),
    .reg_write(rwr[1]), .mem_reg(mrg[1]), .dest_out(dso[1]), .rdata(rd[1]),
    .addr_out(ao[1]), .misalign(mal[1]));

  always #5 clk = ~clk;

  typedef struct {
    int          d;
    int          due;
    logic        mr, mw, lu;
    logic [1:0]  sz, wb;
    logic [4:0]  ds;
    logic [31:0] ad, wd;
  } pend_t;

  pend_t      pq[$];
  logic [7:0] mm [2][4096];
  int         bu [2] = '{-1, -1};
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic cmp(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, d, cyc, got, exp);
    end
  endtask

  // Each accepted op completes at a known cycle; memory effects are applied byte by byte then.
  task automatic model_check();
    int          lat, hit, nb;
    logic        ready, mis;
    logic [31:0] val;
    pend_t       p;
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 0 : LAT1;
      if (!rst) begin
        for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].d == d) pq.delete(i);
        bu[d] = -1;
        cmp("rst_out_valid", d, 32'(ov[d]), 32'd0);
        cmp("rst_reg_write", d, 32'(rwr[d]), 32'd0);
        cmp("rst_misalign",  d, 32'(mal[d]), 32'd0);
        cmp("rst_rdata",     d, rd[d], 32'd0);
        cmp("rst_addr_out",  d, ao[d], 32'd0);
        cmp("rst_in_ready",  d, 32'(rdy[d]), 32'd1);
      end else begin
        hit = -1;
        for (int i = 0; i < pq.size(); i++) if (pq[i].d == d && pq[i].due == cyc) hit = i;
        if (hit >= 0) begin
          p = pq[hit];
          pq.delete(hit);
          nb  = (p.sz == 2'd0) ? 1 : (p.sz == 2'd1) ? 2 : 4;
          mis = (p.mr | p.mw) && ((p.ad % 32'(nb)) != 32'd0);
          val = 32'd0;
          if (p.mw && !mis) begin
            for (int i = 0; i < nb; i++) mm[d][int'((p.ad + 32'(i)) & 32'hFFF)] = p.wd[8*i +: 8];
          end else if (p.mr && !p.mw && !mis) begin
            for (int i = 0; i < nb; i++) val = val | (32'(mm[d][int'((p.ad + 32'(i)) & 32'hFFF)]) << (8*i));
            if (!p.lu && nb == 1 && val[7])  val = val | 32'hFFFFFF00;
            if (!p.lu && nb == 2 && val[15]) val = val | 32'hFFFF0000;
          end
          cmp("out_valid", d, 32'(ov[d]), 32'd1);
          cmp("reg_write", d, 32'(rwr[d]), 32'(p.wb[1] & ~mis));
          cmp("mem_reg",   d, 32'(mrg[d]), 32'(p.wb[0]));
          cmp("dest_out",  d, 32'(dso[d]), 32'(p.ds));
          cmp("rdata",     d, rd[d], val);
          cmp("addr_out",  d, ao[d], p.ad);
          cmp("misalign",  d, 32'(mal[d]), 32'(mis));
        end else begin
          cmp("bubble_out_valid", d, 32'(ov[d]), 32'd0);
          cmp("bubble_reg_write", d, 32'(rwr[d]), 32'd0);
          cmp("bubble_misalign",  d, 32'(mal[d]), 32'd0);
        end
        ready = !(cyc <= bu[d]);
        cmp("in_ready", d, 32'(rdy[d]), 32'(ready));
        cmp("pc_src",   d, 32'(pcs[d]), 32'(iv_d[d] & ready & br & zr));
        if (fl_d[d]) begin
          for (int i = pq.size() - 1; i >= 0; i--) if (pq[i].d == d && pq[i].due > cyc) pq.delete(i);
          if (bu[d] > cyc) bu[d] = cyc;
        end
        if (iv_d[d] && ready && !fl_d[d]) begin
          p = '{d: d, due: cyc + 1, mr: mr, mw: mw, lu: lu, sz: sz, wb: wb, ds: ds, ad: ad, wd: wd};
          if ((mr | mw) && lat > 0) begin
            p.due = cyc + lat + 1;
            bu[d] = cyc + lat;
          end
          pq.push_back(p);
        end
      end
    end
  endtask

  // One clock cycle: drive after the rising edge, check at the falling edge.
  task automatic go(input logic v, b, z, f, r, w, input logic [1:0] s, input logic u,
                    input logic [1:0] wbv, input logic [4:0] dd, input logic [31:0] a, dat);
    @(posedge clk);
    cyc++;
    #1;
    rst = rst_nxt; iv = v; br = b; zr = z; fl = f; mr = r; mw = w;
    sz = s; lu = u; wb = wbv; ds = dd; ad = a; wd = dat;
    @(negedge clk);
    model_check();
  endtask

  task automatic nop();
    go(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0);
  endtask
  task automatic st(input logic [1:0] s, input logic [31:0] a, dat);
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, s, 1'b0, 2'b00, 5'd0, a, dat);
  endtask
  task automatic ld(input logic [1:0] s, input logic u, input logic [31:0] a, input logic [4:0] dd);
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s, u, 2'b11, dd, a, 32'd0);
  endtask
  task automatic alu(input logic [31:0] a, input logic [4:0] dd);
    go(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'b10, dd, a, 32'd0);
  endtask
  task automatic brz();
    go(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'b00, 5'd0, 32'h100, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) nop();
    cmp("lit_reset_in_ready", 0, 32'(rdy[0]), 32'd1);
    cmp("lit_reset_out_valid", 1, 32'(ov[1]), 32'd0);
    rst_nxt = 1'b1;
    nop();

    // Zero-latency instance
    sel = 1'b0;
    st(2'd2, 32'h10, 32'hDEADBEEF);
    ld(2'd2, 1'b0, 32'h10, 5'd5);
    nop();
    cmp("lit_lw_rdata", 0, rd[0], 32'hDEADBEEF);
    cmp("lit_lw_reg_write", 0, 32'(rwr[0]), 32'd1);
    st(2'd0, 32'h13, 32'h00000080);
    ld(2'd0, 1'b0, 32'h13, 5'd6);
    ld(2'd0, 1'b1, 32'h13, 5'd7);
    cmp("lit_lb", 0, rd[0], 32'hFFFFFF80);
    ld(2'd2, 1'b0, 32'h10, 5'd8);
    cmp("lit_lbu", 0, rd[0], 32'h00000080);
    nop();
    cmp("lit_lw_after_sb", 0, rd[0], 32'h80ADBEEF);
    ld(2'd1, 1'b0, 32'h12, 5'd9);
    ld(2'd1, 1'b1, 32'h12, 5'd10);
    cmp("lit_lh", 0, rd[0], 32'hFFFF80AD);
    nop();
    cmp("lit_lhu", 0, rd[0], 32'h000080AD);
    ld(2'd1, 1'b0, 32'h11, 5'd11);
    nop();
    cmp("lit_lh_mis_flag", 0, 32'(mal[0]), 32'd1);
    cmp("lit_lh_mis_reg_write", 0, 32'(rwr[0]), 32'd0);
    cmp("lit_lh_mis_rdata", 0, rd[0], 32'd0);
    st(2'd2, 32'h20, 32'h11223344);
    st(2'd2, 32'h22, 32'hAAAAAAAA);
    ld(2'd2, 1'b0, 32'h20, 5'd12);
    cmp("lit_sw_mis_flag", 0, 32'(mal[0]), 32'd1);
    nop();
    cmp("lit_sw_mis_nowrite", 0, rd[0], 32'h11223344);
    alu(32'h1234, 5'd1);
    alu(32'h5678, 5'd2);
    cmp("lit_alu_addr", 0, ao[0], 32'h00001234);
    alu(32'h9ABC, 5'd3);
    cmp("lit_alu_b2b", 0, ao[0], 32'h00005678);
    brz();
    cmp("lit_pc_src", 0, 32'(pcs[0]), 32'd1);
    st(2'd2, 32'h1010, 32'h0BADF00D);
    go(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'b00, 5'd0, 32'h10, 32'h55555555);
    ld(2'd2, 1'b0, 32'h10, 5'd13);
    nop();
    cmp("lit_wrap_and_flush_drop", 0, rd[0], 32'h0BADF00D);

    // Three-cycle-latency instance
    sel = 1'b1;
    st(2'd2, 32'h40, 32'hCAFEF00D);
    repeat (4) nop();
    ld(2'd2, 1'b0, 32'h40, 5'd14);
    brz();
    cmp("lit_pc_src_busy", 1, 32'(pcs[1]), 32'd0);
    cmp("lit_busy_ready1", 1, 32'(rdy[1]), 32'd0);
    nop();
    cmp("lit_busy_ready2", 1, 32'(rdy[1]), 32'd0);
    nop();
    cmp("lit_busy_ready3", 1, 32'(rdy[1]), 32'd0);
    cmp("lit_busy_bubble", 1, 32'(ov[1]), 32'd0);
    nop();
    cmp("lit_lat3_valid", 1, 32'(ov[1]), 32'd1);
    cmp("lit_lat3_rdata", 1, rd[1], 32'hCAFEF00D);
    alu(32'h111, 5'd1);
    alu(32'h222, 5'd2);
    cmp("lit_lat3_alu_valid", 1, 32'(ov[1]), 32'd1);
    alu(32'h333, 5'd3);
    cmp("lit_lat3_alu_ready", 1, 32'(rdy[1]), 32'd1);
    nop();
    st(2'd2, 32'h40, 32'h99999999);
    nop();
    go(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0);
    nop();
    cmp("lit_flush_ready", 1, 32'(rdy[1]), 32'd1);
    cmp("lit_flush_no_valid", 1, 32'(ov[1]), 32'd0);
    ld(2'd2, 1'b0, 32'h40, 5'd15);
    repeat (4) nop();
    cmp("lit_flush_no_store", 1, rd[1], 32'hCAFEF00D);
    ld(2'd1, 1'b0, 32'h41, 5'd16);
    repeat (4) nop();
    cmp("lit_lat3_misalign", 1, 32'(mal[1]), 32'd1);
    st(2'd2, 32'h40, 32'h77777777);
    nop();
    rst_nxt = 1'b0;
    nop();
    cmp("lit_rst_busy_valid", 1, 32'(ov[1]), 32'd0);
    cmp("lit_rst_busy_ready", 1, 32'(rdy[1]), 32'd1);
    rst_nxt = 1'b1;
    nop();
    ld(2'd2, 1'b0, 32'h40, 5'd17);
    repeat (4) nop();
    cmp("lit_rst_no_store", 1, rd[1], 32'hCAFEF00D);
    repeat (2) nop();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
